// File: rtl/scoreboard_button_conditioner.sv
// Conditions the raw up/down scoreboard buttons into clean one-cycle count pulses.
// Optional auto-repeat while a button is held: define SCOREBOARD_AUTOREPEAT_EN.
module scoreboard_button_conditioner #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_up_i,
    input  logic btn_down_i,
    output logic up_pulse_o,
    output logic down_pulse_o,
    output logic up_level_o,
    output logic down_level_o
);

    localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

    // Channel index 0 is up, 1 is down.
    logic [1:0] w_btn;
    logic [1:0] w_sync;
    logic [1:0] w_level;
    logic [1:0] w_hit;
    logic [1:0] w_rise;
    logic [1:0] w_press;
    logic [1:0] w_pulse_nxt;
    logic [1:0] r_pulse;

    assign w_btn = {btn_down_i, btn_up_i};

    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic        r_s1;
        logic        r_s2;
        logic        r_level;
        logic [15:0] r_cnt;

        // Two-flop synchronizer followed by a stability counter.
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1 <= w_btn[g];
                r_s2 <= r_s1;
                if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == DB_LAST) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end

        assign w_sync[g]  = r_s2;
        assign w_level[g] = r_level;
        assign w_hit[g]   = (r_s2 != r_level) && (r_cnt == DB_LAST);
    end

    // A level flip this edge toward 1 is a press event.
    assign w_rise = w_hit & w_sync;

    always_comb begin
        w_press    = 2'b00;
        w_press[0] = w_rise[0] & ~w_rise[1] & ~w_level[1];
        w_press[1] = w_rise[1] & ~w_rise[0] & ~w_level[0];
    end

`ifdef SCOREBOARD_AUTOREPEAT_EN
    localparam logic [23:0] RD_LAST = REPEAT_DELAY - 24'd1;
    localparam logic [23:0] RP_LAST = REPEAT_PERIOD - 24'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_t;

    logic [1:0] w_level_nxt;
    logic [1:0] w_rpt;

    assign w_level_nxt = w_level ^ w_hit;

    for (genvar g = 0; g < 2; g++) begin : g_rpt
        localparam int unsigned OTH = (g == 0) ? 1 : 0;

        rpt_state_t  r_state;
        logic [23:0] r_timer;
        logic        w_abort;
        logic        w_due;

        // Holding the other button, or releasing this one, cancels repeats at once.
        assign w_abort  = !w_level_nxt[g] || w_level_nxt[OTH];
        assign w_due    = ((r_state == ST_DELAY)  && (r_timer == RD_LAST)) ||
                          ((r_state == ST_REPEAT) && (r_timer == RP_LAST));
        assign w_rpt[g] = w_due && !w_abort;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
            end else if (w_abort) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_timer <= '0;
                        if (w_press[g]) r_state <= ST_DELAY;
                    end
                    ST_DELAY: begin
                        if (r_timer == RD_LAST) begin
                            r_state <= ST_REPEAT;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 24'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (r_timer == RP_LAST) r_timer <= '0;
                        else                    r_timer <= r_timer + 24'd1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                    end
                endcase
            end
        end
    end

    assign w_pulse_nxt = w_press | w_rpt;
`else
    logic w_unused_params;
    assign w_unused_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign w_pulse_nxt     = w_press;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_pulse <= 2'b00;
        else          r_pulse <= w_pulse_nxt;
    end

    assign up_pulse_o   = r_pulse[0];
    assign down_pulse_o = r_pulse[1];
    assign up_level_o   = w_level[0];
    assign down_level_o = w_level[1];

endmodule

// File: tb/tb_scoreboard_button_conditioner.sv
// Scoreboard bench: stimulus queues expected level/pulse events, a monitor matches observed ones.
// Covers the repeat scenarios too when SCOREBOARD_AUTOREPEAT_EN is defined.
module tb_scoreboard_button_conditioner;

    localparam int K_UP_R = 0, K_UP_F = 1, K_DN_R = 2, K_DN_F = 3, K_UP_P = 4, K_DN_P = 5;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;
    logic btn_up_i = 1'b0;
    logic btn_down_i = 1'b0;
    logic up_pulse_o, down_pulse_o, up_level_o, down_level_o;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];
    logic prev_up_lvl = 1'b0, prev_dn_lvl = 1'b0;

    scoreboard_button_conditioner #(
        .DEBOUNCE_CYCLES(16'd4),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_PERIOD  (24'd8)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .btn_up_i    (btn_up_i),
        .btn_down_i  (btn_down_i),
        .up_pulse_o  (up_pulse_o),
        .down_pulse_o(down_pulse_o),
        .up_level_o  (up_level_o),
        .down_level_o(down_level_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_UP_R:  return "up_level_rise";
            K_UP_F:  return "up_level_fall";
            K_DN_R:  return "down_level_rise";
            K_DN_F:  return "down_level_fall";
            K_UP_P:  return "up_pulse";
            default: return "down_pulse";
        endcase
    endfunction

    task automatic push(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Expected events for one isolated press of channel ch sampled at edge e0, held `hold` cycles.
    task automatic push_press(input int ch, input int e0, input int hold);
        push(e0 + 5, ch ? K_DN_R : K_UP_R);
        push(e0 + 5, ch ? K_DN_P : K_UP_P);
`ifdef SCOREBOARD_AUTOREPEAT_EN
        for (int e = e0 + 25; e < e0 + hold + 5; e += 8) push(e, ch ? K_DN_P : K_UP_P);
`endif
        push(e0 + hold + 5, ch ? K_DN_F : K_UP_F);
    endtask

    task automatic observe(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                errors++;
                $display("FAIL event_match: got %s at cycle %0d, required %s at cycle %0d",
                         kname(k), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every output change is an event to be matched against the scoreboard.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (up_level_o != prev_up_lvl) observe(up_level_o ? K_UP_R : K_UP_F);
            if (down_level_o != prev_dn_lvl) observe(down_level_o ? K_DN_R : K_DN_F);
            if (up_pulse_o) observe(K_UP_P);
            if (down_pulse_o) observe(K_DN_P);
        end
        prev_up_lvl = up_level_o;
        prev_dn_lvl = down_level_o;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        logic [3:0] got;
        got = {up_pulse_o, down_pulse_o, up_level_o, down_level_o};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL %s: outputs {upP,dnP,upL,dnL}=%b, required 0000", name, got);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        wait_edges(3);
        check_all_zero("reset_state");
        rst_n_i = 1'b1;
        wait_edges(3);

        // Clean up press held 30 cycles
        btn_up_i = 1'b1;
        e0 = cyc + 1;
        push_press(0, e0, 30);
        wait_edges(30);
        btn_up_i = 1'b0;
        wait_edges(12);

        // Clean down press held 20 cycles
        btn_down_i = 1'b1;
        e0 = cyc + 1;
        push_press(1, e0, 20);
        wait_edges(20);
        btn_down_i = 1'b0;
        wait_edges(12);

        // Bouncing down press: 3 high / 1 low, four times, then steady
        for (int i = 0; i < 4; i++) begin
            btn_down_i = 1'b1;
            wait_edges(3);
            btn_down_i = 1'b0;
            wait_edges(1);
        end
        btn_down_i = 1'b1;
        e0 = cyc + 1;
        push_press(1, e0, 15);
        wait_edges(15);
        btn_down_i = 1'b0;
        wait_edges(12);

        // Simultaneous press: levels rise, no pulses
        btn_up_i = 1'b1;
        btn_down_i = 1'b1;
        e0 = cyc + 1;
        push(e0 + 5, K_UP_R);
        push(e0 + 5, K_DN_R);
        push(e0 + 25, K_UP_F);
        push(e0 + 25, K_DN_F);
        wait_edges(20);
        btn_up_i = 1'b0;
        btn_down_i = 1'b0;
        wait_edges(12);

        // Up pressed while down already held: no up pulse
        btn_down_i = 1'b1;
        e0 = cyc + 1;
        push(e0 + 5, K_DN_R);
        push(e0 + 5, K_DN_P);
        push(e0 + 15, K_UP_R);
        push(e0 + 25, K_UP_F);
        push(e0 + 35, K_DN_F);
        wait_edges(10);
        btn_up_i = 1'b1;
        wait_edges(10);
        btn_up_i = 1'b0;
        wait_edges(10);
        btn_down_i = 1'b0;
        wait_edges(12);

        // Reset at edge 3 of an up press, button kept high
        btn_up_i = 1'b1;
        e0 = cyc + 1;
        wait_edges(4);
        rst_n_i = 1'b0;
        #1;
        check_all_zero("reset_mid_a");
        wait_edges(1);
        check_all_zero("reset_mid_b");
        wait_edges(1);
        rst_n_i = 1'b1;
        e0 = cyc + 1;
        push_press(0, e0, 20);
        wait_edges(20);
        btn_up_i = 1'b0;
        wait_edges(12);

`ifdef SCOREBOARD_AUTOREPEAT_EN
        // Long hold: repeats at 25, 33, 41, 49, 57
        btn_up_i = 1'b1;
        e0 = cyc + 1;
        push_press(0, e0, 60);
        wait_edges(60);
        btn_up_i = 1'b0;
        wait_edges(12);

        // Down pressed mid-hold cancels the repeat due at edge 33
        btn_up_i = 1'b1;
        e0 = cyc + 1;
        push(e0 + 5, K_UP_R);
        push(e0 + 5, K_UP_P);
        push(e0 + 25, K_UP_P);
        push(e0 + 33, K_DN_R);
        push(e0 + 45, K_DN_F);
        push(e0 + 55, K_UP_F);
        wait_edges(28);
        btn_down_i = 1'b1;
        wait_edges(12);
        btn_down_i = 1'b0;
        wait_edges(10);
        btn_up_i = 1'b0;
        wait_edges(12);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, first %s at cycle %0d, required 0",
                     exp_q.size(), kname(exp_q[0].kind), exp_q[0].cyc);
        end
        check_all_zero("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
